sprite_fetch: RTL and testbench
===============================

Name: sprite_fetch

Overview:
- Pixel-source stage directly upstream of the 800x600 VGA timing/output stage.
- Takes the live hcount/vcount from the timing generator and places one IMG_W x IMG_H RGB332 image at a programmable position, with optional power-of-two upscaling.
- Generates image ROM addresses incrementally, with no multiplier, and returns a registered RGB332 pixel per clock for the output stage to drive onto red/green/blue.
- Position and enable are shadowed at frame boundaries so moving the image never tears.

Parameters:
- IMG_W, 168, image width in pixels.
- IMG_H, 192, image height in pixels.
- SCALE_LOG2, 0, each image pixel is drawn as a 2^SCALE_LOG2 square (0..3).
- H_ACTIVE, 800, visible pixels per line.
- V_ACTIVE, 600, visible lines per frame.
- H_TOTAL, 1056, clocks per line.
- V_TOTAL, 628, lines per frame.
- BG_COLOR, 8'h04, RGB332 colour for active pixels outside the image.
- ADDR_W, 16, ROM address width; must satisfy IMG_W*IMG_H <= 2^ADDR_W.

Ports:
- clk  in  1  pixel clock (40 MHz).
- reset  in  1  asynchronous, active-high reset.
- hcount  in  11  current horizontal position, 0..H_TOTAL-1.
- vcount  in  10  current vertical position, 0..V_TOTAL-1.
- pos_x  in  11  requested image left edge in pixels.
- pos_y  in  10  requested image top edge in lines.
- enable  in  1  requested image visibility.
- rom_addr  out  ADDR_W  image ROM address; the ROM has a combinational read.
- rom_data  in  8  RGB332 word at rom_addr, same cycle.
- rgb  out  8  RGB332 pixel, {r[2:0], g[2:0], b[1:0]}.
- frame_start  out  1  one-cycle pulse after the shadow registers load.

Behaviour:
- Reset (async, active-high) clears:
  - rom_addr=0, rgb=0, frame_start=0.
  - Shadow sh_x=0, sh_y=0, sh_en=0.
  - row_base=0, col_addr=0, hsub=0, vsub=0, row_cnt=0, and all pipeline flags=0.
- Reset mid-frame: after release, sh_en=0, so every active pixel outputs BG_COLOR until the next frame latch.
- Frame latch: on the cycle with hcount==H_TOTAL-1 and vcount==V_TOTAL-1:
  - sh_x<=pos_x, sh_y<=pos_y, sh_en<=enable.
  - row_base<=0, vsub<=0, row_cnt<=0.
  - frame_start=1 on the next cycle only.
  - pos_x, pos_y and enable changes at any other time have no effect.
- Window: WX=IMG_W<<SCALE_LOG2, WY=IMG_H<<SCALE_LOG2. Compute in 12 bits so sh_x+WX cannot wrap.
  - in_x = hcount>=sh_x && hcount<sh_x+WX.
  - in_y = vcount>=sh_y && row_cnt<IMG_H.
  - in_win = sh_en && in_x && in_y && hcount<H_ACTIVE && vcount<V_ACTIVE.
- Horizontal addressing:
  - When hcount==sh_x on a line with in_y: col_addr<=row_base+1 if SCALE_LOG2==0, else row_base; hsub<=1.
  - Otherwise, while in_x && in_y: hsub increments modulo 2^SCALE_LOG2; col_addr increments when hsub wraps to 0.
  - Address presented for the current pixel = (hcount==sh_x) ? row_base : col_addr.
  - This addressing runs even when clipped at H_ACTIVE, so clipping never corrupts rows.
- Vertical addressing: at hcount==H_TOTAL-1 with in_y:
  - vsub increments modulo 2^SCALE_LOG2.
  - On wrap: row_base<=row_base+IMG_W and row_cnt<=row_cnt+1.
  - The row_cnt==IMG_H limit caps the last address at IMG_W*IMG_H-1; rom_addr never exceeds it.
- Pipeline, with latency 2 from the hcount/vcount sample at cycle t:
  - t+1: rom_addr<=address if in_win, else it holds its previous value (no toggling); flags win_d and act_d are registered.
  - t+2: rgb <= win_d ? rom_data : (act_d ? BG_COLOR : 8'h00), where act_d = hcount<H_ACTIVE && vcount<V_ACTIVE.
- The downstream stage delays hsync and vsync by 2 clocks to match this latency.
- Clipping: the window may extend past H_ACTIVE or V_ACTIVE; off-screen pixels are never shown, and on-screen pixels remain address-correct.
- pos_x>=H_ACTIVE or pos_y>=V_ACTIVE: image fully invisible, and the output is the BG_COLOR/0 pattern only.

Test Plan:
- Defaults, pos=(10,10), enable=1, ROM[i]=i[7:0]:
  - At hcount=10, vcount=10: rom_addr=0 at t+1, rgb=8'h00 at t+2.
  - hcount=177, vcount=10 -> addr 167.
  - hcount=10, vcount=11 -> addr 168.
  - hcount=177, vcount=201 -> addr 32255.
  - hcount=178 or vcount=202 -> rgb=8'h04.
  - hcount>=800 -> rgb=0.
- SCALE_LOG2=1, pos=(0,0):
  - hcount 0,1 -> addr 0; hcount 2,3 -> addr 1.
  - Lines 0 and 1 share base 0; line 2 starts at 168.
  - Last address 32255 at vcount=383; line 384 -> BG.
- Clipping, pos_x=700, pos_y=500:
  - hcount=799 -> addr 99; hcount 800..867 -> rgb 0.
  - The next line starts at addr 168.
  - vcount=599 is the last image row shown (row 99).
- Mid-frame change: set pos_x 10->300 and enable 1->0 at vcount=50.
  - The rest of the frame is unchanged (window still at x=10).
  - frame_start pulses once at the wrap.
  - The next frame shows all active pixels = 8'h04.
- Async reset asserted at hcount=100, vcount=20 for 3 cycles:
  - rgb, rom_addr and frame_start go to 0 immediately, without waiting for a clk edge.
  - After release, active pixels = 8'h04 until the frame latch.
  - The following frame is addressed correctly from 0.

Source files
------------

// File: rtl/sprite_fetch.sv
// Pixel source for the 800x600 VGA output stage: places one RGB332 image at a
// frame-latched position with optional power-of-two upscaling. Latency is 2 clocks.
module sprite_fetch #(
  parameter int          IMG_W      = 168,
  parameter int          IMG_H      = 192,
  parameter int          SCALE_LOG2 = 0,
  parameter int          H_ACTIVE   = 800,
  parameter int          V_ACTIVE   = 600,
  parameter int          H_TOTAL    = 1056,
  parameter int          V_TOTAL    = 628,
  parameter logic [7:0]  BG_COLOR   = 8'h04,
  parameter int          ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       hcount,
  input  logic [9:0]        vcount,
  input  logic [10:0]       pos_x,
  input  logic [9:0]        pos_y,
  input  logic              enable,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        rgb,
  output logic              frame_start
);

  localparam int SW   = (SCALE_LOG2 == 0) ? 1 : SCALE_LOG2;
  localparam int RC_W = $clog2(IMG_H + 1);

  localparam logic [SW-1:0]     SUB_MASK   = SW'((32'd1 << SCALE_LOG2) - 32'd1);
  localparam logic [11:0]       WX         = 12'(IMG_W << SCALE_LOG2);
  localparam logic [10:0]       H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [9:0]        V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [10:0]       H_ACT      = 11'(H_ACTIVE);
  localparam logic [9:0]        V_ACT      = 10'(V_ACTIVE);
  localparam logic [RC_W-1:0]   ROWS       = RC_W'(IMG_H);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] FIRST_STEP = (SCALE_LOG2 == 0) ? ADDR_W'(1) : '0;

  logic [10:0]       sh_x;
  logic [9:0]        sh_y;
  logic              sh_en;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] col_addr;
  logic [SW-1:0]     hsub;
  logic [SW-1:0]     vsub;
  logic [RC_W-1:0]   row_cnt;
  logic              win_d;
  logic              act_d;

  logic              frame_last;
  logic              line_last;
  logic              at_left;
  logic [11:0]       x_end;
  logic              in_x;
  logic              in_y;
  logic              active;
  logic              in_win;
  logic [ADDR_W-1:0] pix_addr;
  logic [SW-1:0]     hsub_nxt;
  logic [SW-1:0]     vsub_nxt;

  always_comb begin
    frame_last = (hcount == H_LAST) && (vcount == V_LAST);
    line_last  = (hcount == H_LAST);
    at_left    = (hcount == sh_x);
    // 12-bit end so a window near the right edge of the 11-bit range cannot wrap
    x_end      = {1'b0, sh_x} + WX;
    in_x       = (hcount >= sh_x) && ({1'b0, hcount} < x_end);
    in_y       = (vcount >= sh_y) && (row_cnt < ROWS);
    active     = (hcount < H_ACT) && (vcount < V_ACT);
    in_win     = sh_en && in_x && in_y && active;
    pix_addr   = at_left ? row_base : col_addr;
    hsub_nxt   = (hsub + SW'(1)) & SUB_MASK;
    vsub_nxt   = (vsub + SW'(1)) & SUB_MASK;
  end

  // Frame shadow registers and per-line row advance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_x        <= '0;
      sh_y        <= '0;
      sh_en       <= 1'b0;
      row_base    <= '0;
      vsub        <= '0;
      row_cnt     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_last;
      if (frame_last) begin
        sh_x     <= pos_x;
        sh_y     <= pos_y;
        sh_en    <= enable;
        row_base <= '0;
        vsub     <= '0;
        row_cnt  <= '0;
      end else if (line_last && in_y) begin
        vsub <= vsub_nxt;
        if (vsub_nxt == '0) begin
          row_base <= row_base + ROW_STRIDE;
          row_cnt  <= row_cnt + RC_W'(1);
        end
      end
    end
  end

  // Column walk: the left-edge pixel reads row_base directly, so col_addr is
  // preloaded one step ahead of it and then advances once per 2^SCALE_LOG2 pixels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_addr <= '0;
      hsub     <= '0;
    end else if (at_left && in_y) begin
      col_addr <= row_base + FIRST_STEP;
      hsub     <= SW'(1) & SUB_MASK;
    end else if (in_x && in_y) begin
      hsub <= hsub_nxt;
      if (hsub_nxt == '0) col_addr <= col_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_addr <= '0;
      win_d    <= 1'b0;
      act_d    <= 1'b0;
      rgb      <= '0;
    end else begin
      if (in_win) rom_addr <= pix_addr;
      win_d <= in_win;
      act_d <= active;
      rgb   <= win_d ? rom_data : (act_d ? BG_COLOR : 8'h00);
    end
  end

endmodule

// File: tb/tb_sprite_fetch.sv
// Directed bench for sprite_fetch: one instance at 1x scale, one at 2x,
// with a ROM whose contents are the low address byte.
module tb_sprite_fetch;

  localparam int H_LAST = 1055;
  localparam int V_LAST = 627;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [10:0] pos_x;
  logic [9:0]  pos_y;
  logic        enable;

  logic [15:0] rom_addr_a, rom_addr_b;
  logic [7:0]  rom_data_a, rom_data_b;
  logic [7:0]  rgb_a, rgb_b;
  logic        fs_a, fs_b;

  int checks = 0;
  int errors = 0;

  bit    pend_v;
  bit    pend_sel;
  int    pend_r;
  string pend_tag;

  assign rom_data_a = rom_addr_a[7:0];
  assign rom_data_b = rom_addr_b[7:0];

  always #5 clk = ~clk;

  sprite_fetch u_dut_a (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .pos_x(pos_x), .pos_y(pos_y), .enable(enable),
    .rom_addr(rom_addr_a), .rom_data(rom_data_a), .rgb(rgb_a), .frame_start(fs_a)
  );

  sprite_fetch #(.SCALE_LOG2(1)) u_dut_b (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .pos_x(pos_x), .pos_y(pos_y), .enable(enable),
    .rom_addr(rom_addr_b), .rom_data(rom_data_b), .rgb(rgb_b), .frame_start(fs_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input int req);
    checks++;
    assert (obs === 32'(req)) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  // One pixel clock at (h,v); optionally expects an address at t+1 and a colour at t+2.
  task automatic step(input int h, input int v, input bit sel, input bit ca, input int a,
                      input bit cr, input int r, input string tag);
    hcount = 11'(h);
    vcount = 10'(v);
    @(posedge clk);
    #1;
    if (ca) check({tag, " addr"}, 32'(sel ? rom_addr_b : rom_addr_a), a);
    if (pend_v) check({pend_tag, " rgb"}, 32'(pend_sel ? rgb_b : rgb_a), pend_r);
    pend_v   = cr;
    pend_sel = sel;
    pend_r   = r;
    pend_tag = tag;
  endtask

  task automatic idle(input int h, input int v);
    step(h, v, 1'b0, 1'b0, 0, 1'b0, 0, "");
  endtask

  task automatic run(input int h0, input int h1, input int v);
    for (int h = h0; h <= h1; h++) idle(h, v);
  endtask

  task automatic skip_lines(input int v0, input int v1);
    for (int v = v0; v <= v1; v++) idle(H_LAST, v);
  endtask

  task automatic latch();
    idle(H_LAST, V_LAST);
    check("fs_pulse_a", 32'(fs_a), 1);
    check("fs_pulse_b", 32'(fs_b), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; hcount = '0; vcount = '0;
    pos_x = '0; pos_y = '0; enable = 1'b0; pend_v = 1'b0;
    #1;
    check("rst_rgb", 32'(rgb_a), 0);
    check("rst_addr", 32'(rom_addr_a), 0);
    check("rst_fs", 32'(fs_a), 0);
    check("rst_rgb_b", 32'(rgb_b), 0);
    @(posedge clk); #1 reset = 1'b0;

    // Before any frame latch the image is disabled
    step(5, 5, 0, 0, 0, 1, 8'h04, "pre_bg");
    step(900, 5, 0, 0, 0, 1, 8'h00, "pre_hblank");
    idle(1000, 5);

    // Scale 1, image at (10,10)
    pos_x = 11'd10; pos_y = 10'd10; enable = 1'b1;
    latch();
    idle(H_LAST, 0);
    check("fs_drop", 32'(fs_a), 0);
    skip_lines(1, 9);
    run(0, 9, 10);
    step(10, 10, 0, 1, 0, 1, 8'h00, "A_first");
    run(11, 176, 10);
    step(177, 10, 0, 1, 167, 1, 8'hA7, "A_lastcol");
    step(178, 10, 0, 1, 167, 1, 8'h04, "A_right_bg");
    run(179, 799, 10);
    step(800, 10, 0, 0, 0, 1, 8'h00, "A_hblank");
    idle(H_LAST, 10);
    step(10, 11, 0, 1, 168, 1, 8'hA8, "A_row1");
    idle(H_LAST, 11);
    skip_lines(12, 200);
    run(10, 176, 201);
    step(177, 201, 0, 1, 32255, 1, 8'hFF, "A_lastaddr");
    idle(H_LAST, 201);
    step(10, 202, 0, 1, 32255, 1, 8'h04, "A_below_bg");
    idle(H_LAST, 202);
    step(10, 601, 0, 0, 0, 1, 8'h00, "A_vblank");
    idle(H_LAST, 601);

    // Scale 2 instance, image at (0,0)
    pos_x = 11'd0; pos_y = 10'd0; enable = 1'b1;
    latch();
    step(0, 0, 1, 1, 0, 1, 8'h00, "B_h0");
    step(1, 0, 1, 1, 0, 1, 8'h00, "B_h1");
    step(2, 0, 1, 1, 1, 1, 8'h01, "B_h2");
    step(3, 0, 1, 1, 1, 1, 8'h01, "B_h3");
    idle(H_LAST, 0);
    step(0, 1, 1, 1, 0, 1, 8'h00, "B_line1");
    idle(H_LAST, 1);
    step(0, 2, 1, 1, 168, 1, 8'hA8, "B_line2");
    idle(H_LAST, 2);
    skip_lines(3, 382);
    run(0, 333, 383);
    step(334, 383, 1, 1, 32255, 1, 8'hFF, "B_lastcol0");
    step(335, 383, 1, 1, 32255, 1, 8'hFF, "B_lastcol1");
    step(336, 383, 1, 1, 32255, 1, 8'h04, "B_right_bg");
    idle(H_LAST, 383);
    step(0, 384, 1, 1, 32255, 1, 8'h04, "B_below_bg");
    idle(H_LAST, 384);

    // Clipping at the right and bottom edges
    pos_x = 11'd700; pos_y = 10'd500; enable = 1'b1;
    latch();
    run(690, 699, 500);
    step(700, 500, 0, 1, 0, 1, 8'h00, "C_first");
    run(701, 798, 500);
    step(799, 500, 0, 1, 99, 1, 8'h63, "C_clip_last");
    step(800, 500, 0, 1, 99, 1, 8'h00, "C_offscreen");
    run(801, 866, 500);
    step(867, 500, 0, 1, 99, 1, 8'h00, "C_offscreen_end");
    idle(H_LAST, 500);
    step(700, 501, 0, 1, 168, 1, 8'hA8, "C_row1");
    idle(H_LAST, 501);
    skip_lines(502, 598);
    step(700, 599, 0, 1, 16632, 1, 8'hF8, "C_lastrow");
    idle(H_LAST, 599);
    step(700, 600, 0, 1, 16632, 1, 8'h00, "C_vclip");
    idle(H_LAST, 600);

    // Mid-frame position/enable change takes effect only at the next frame
    pos_x = 11'd10; pos_y = 10'd10; enable = 1'b1;
    latch();
    skip_lines(0, 49);
    pos_x = 11'd300; enable = 1'b0;
    run(0, 9, 50);
    step(10, 50, 0, 1, 6720, 1, 8'h40, "D_still_x10");
    run(11, 176, 50);
    step(177, 50, 0, 1, 6887, 1, 8'hE7, "D_old_window");
    run(178, 299, 50);
    step(300, 50, 0, 1, 6887, 1, 8'h04, "D_new_x_ignored");
    idle(H_LAST, 50);
    skip_lines(51, 626);
    check("D_fs_idle", 32'(fs_a), 0);
    latch();
    idle(H_LAST, 0);
    check("D_fs_once", 32'(fs_a), 0);
    skip_lines(1, 9);
    step(10, 10, 0, 1, 6887, 1, 8'h04, "D_disabled");
    step(300, 10, 0, 1, 6887, 1, 8'h04, "D_disabled_newx");
    idle(H_LAST, 10);

    // Asynchronous reset in the middle of a frame
    pos_x = 11'd10; pos_y = 10'd10; enable = 1'b1;
    latch();
    skip_lines(0, 19);
    run(0, 98, 20);
    step(99, 20, 0, 1, 1769, 1, 8'hE9, "E_pre99");
    step(100, 20, 0, 1, 1770, 0, 0, "E_pre100");
    reset = 1'b1;
    #1;
    check("E_rst_rgb", 32'(rgb_a), 0);
    check("E_rst_addr", 32'(rom_addr_a), 0);
    check("E_rst_fs", 32'(fs_a), 0);
    idle(101, 20);
    idle(102, 20);
    idle(103, 20);
    reset = 1'b0;
    run(104, 149, 20);
    step(150, 20, 0, 1, 0, 1, 8'h04, "E_post_bg");
    step(900, 20, 0, 0, 0, 1, 8'h00, "E_post_blank");
    idle(H_LAST, 20);
    skip_lines(21, 626);
    latch();
    skip_lines(0, 9);
    step(10, 10, 0, 1, 0, 1, 8'h00, "E_recover_first");
    step(11, 10, 0, 1, 1, 1, 8'h01, "E_recover_second");
    idle(H_LAST, 10);
    step(10, 11, 0, 1, 168, 1, 8'hA8, "E_recover_row1");
    idle(H_LAST, 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
